// File: rtl/timed_logic_gate.sv
// N-input gate (AND/OR/NAND/NOR) whose output transitions are delayed by
// programmable rise/fall cycle counts with inertial glitch filtering.
module timed_logic_gate #(
    parameter int unsigned N    = 2,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 16,
    parameter logic        INIT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  a,
    input  logic [1:0]    op,
    input  logic [DW-1:0] rise_dly,
    input  logic [DW-1:0] fall_dly,
    output logic          z,
    output logic          pending,
    output logic          z_evt,
    output logic [CW-1:0] filt_cnt
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t        r_state;
    logic [DW-1:0] r_cnt;
    logic          r_z;
    logic          r_evt;
    logic [CW-1:0] r_filt;

    logic          w_tgt;
    logic [DW-1:0] w_d;

    always_comb begin
        w_tgt = 1'b0;
        case (op)
            2'd0:    w_tgt = &a;
            2'd1:    w_tgt = |a;
            2'd2:    w_tgt = ~(&a);
            default: w_tgt = ~(|a);
        endcase
        w_d = w_tgt ? rise_dly : fall_dly;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_z     <= INIT;
            r_evt   <= 1'b0;
            r_filt  <= '0;
        end else begin
            r_evt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tgt != r_z) begin
                        if (w_d <= DW'(1)) begin
                            r_z   <= w_tgt;
                            r_evt <= 1'b1;
                        end else begin
                            // delay is latched here; later rise/fall changes don't affect this event
                            r_cnt   <= w_d - DW'(1);
                            r_state <= PEND;
                        end
                    end
                end
                PEND: begin
                    // a revert wins over a simultaneous expiry
                    if (w_tgt == r_z) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        if (r_filt != '1) r_filt <= r_filt + CW'(1);
                    end else if (r_cnt == DW'(1)) begin
                        r_z     <= w_tgt;
                        r_evt   <= 1'b1;
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - DW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign z        = r_z;
    assign pending  = (r_state == PEND);
    assign z_evt    = r_evt;
    assign filt_cnt = r_filt;

endmodule

// File: tb/tb_timed_logic_gate.sv
// Scoreboard bench for timed_logic_gate: each driven cycle pushes the outputs
// expected after the next edge; a monitor pops and compares them after that edge.
module tb_timed_logic_gate;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_NAND = 2'd2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: INIT=0, CW=16
    logic        rst_a = 1'b1;
    logic [1:0]  a_a = 2'b00, op_a = OP_AND;
    logic [7:0]  rise_a = 8'd5, fall_a = 8'd3;
    logic        z_a, pend_a, evt_a;
    logic [15:0] filt_a;

    // DUT B: INIT=1, CW=2
    logic        rst_b = 1'b1;
    logic [1:0]  a_b = 2'b11, op_b = OP_AND;
    logic [7:0]  rise_b = 8'd3, fall_b = 8'd3;
    logic        z_b, pend_b, evt_b;
    logic [1:0]  filt_b;

    timed_logic_gate #(.N(2), .DW(8), .CW(16), .INIT(1'b0)) u_dut_a (
        .clk(clk), .reset(rst_a), .a(a_a), .op(op_a),
        .rise_dly(rise_a), .fall_dly(fall_a),
        .z(z_a), .pending(pend_a), .z_evt(evt_a), .filt_cnt(filt_a)
    );

    timed_logic_gate #(.N(2), .DW(8), .CW(2), .INIT(1'b1)) u_dut_b (
        .clk(clk), .reset(rst_b), .a(a_b), .op(op_b),
        .rise_dly(rise_b), .fall_dly(fall_b),
        .z(z_b), .pending(pend_b), .z_evt(evt_b), .filt_cnt(filt_b)
    );

    typedef struct {
        string       tag;
        bit          dut;
        logic        z;
        logic        p;
        logic        e;
        int unsigned f;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive one cycle of stimulus and record what the DUT must show after the edge.
    task automatic step(input string tag, input bit dut, input logic [1:0] ia,
                        input logic [1:0] iop, input logic rst, input logic ez,
                        input logic ep, input logic ee, input int unsigned ef);
        exp_t x;
        if (!dut) begin
            a_a = ia; op_a = iop; rst_a = rst;
        end else begin
            a_b = ia; op_b = iop; rst_b = rst;
        end
        x.tag = tag; x.dut = dut; x.z = ez; x.p = ep; x.e = ee; x.f = ef;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.dut) begin
                    check({e.tag, ".z"},    32'(z_a),    32'(e.z));
                    check({e.tag, ".pend"}, 32'(pend_a), 32'(e.p));
                    check({e.tag, ".zevt"}, 32'(evt_a),  32'(e.e));
                    check({e.tag, ".filt"}, 32'(filt_a), e.f);
                end else begin
                    check({e.tag, ".z"},    32'(z_b),    32'(e.z));
                    check({e.tag, ".pend"}, 32'(pend_b), 32'(e.p));
                    check({e.tag, ".zevt"}, 32'(evt_b),  32'(e.e));
                    check({e.tag, ".filt"}, 32'(filt_b), e.f);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #2;
        // ---- DUT A ----
        step("a_rst0", 0, 2'b00, OP_AND, 1, 0, 0, 0, 0);
        step("a_rst1", 0, 2'b00, OP_AND, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("a_idle", 0, 2'b00, OP_AND, 0, 0, 0, 0, 0);

        // rise=5: change sampled at edge k, z rises at edge k+4
        step("t1_k0", 0, 2'b11, OP_AND, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("t1_pend", 0, 2'b11, OP_AND, 0, 0, 1, 0, 0);
        step("t1_rise", 0, 2'b11, OP_AND, 0, 1, 0, 1, 0);
        step("t1_hold", 0, 2'b11, OP_AND, 0, 1, 0, 0, 0);

        // fall=3: z falls at edge k+2
        step("t2_k0", 0, 2'b01, OP_AND, 0, 1, 1, 0, 0);
        step("t2_pend", 0, 2'b01, OP_AND, 0, 1, 1, 0, 0);
        step("t2_fall", 0, 2'b01, OP_AND, 0, 0, 0, 1, 0);
        step("t2_hold", 0, 2'b01, OP_AND, 0, 0, 0, 0, 0);

        // glitch under OR with rise=6
        rise_a = 8'd6;
        for (int i = 0; i < 3; i++) step("t3_glitch", 0, 2'b01, OP_OR, 0, 0, 1, 0, 0);
        step("t3_revert", 0, 2'b00, OP_OR, 0, 0, 0, 0, 1);
        step("t3_hold", 0, 2'b00, OP_OR, 0, 0, 0, 0, 1);

        // zero and one cycle delays: immediate update, never pending
        rise_a = 8'd0; fall_a = 8'd0;
        step("t4_r0", 0, 2'b11, OP_AND, 0, 1, 0, 1, 1);
        step("t4_r0_hold", 0, 2'b11, OP_AND, 0, 1, 0, 0, 1);
        step("t4_f0", 0, 2'b00, OP_AND, 0, 0, 0, 1, 1);
        rise_a = 8'd1; fall_a = 8'd1;
        step("t4_r1", 0, 2'b11, OP_AND, 0, 1, 0, 1, 1);
        step("t4_r1_hold", 0, 2'b11, OP_AND, 0, 1, 0, 0, 1);
        step("t4_f1", 0, 2'b00, OP_AND, 0, 0, 0, 1, 1);

        // latched delay: rise=4, then rise=1 mid-event
        rise_a = 8'd4;
        step("t5_k0", 0, 2'b11, OP_AND, 0, 0, 1, 0, 1);
        rise_a = 8'd1;
        step("t5_pend1", 0, 2'b11, OP_AND, 0, 0, 1, 0, 1);
        step("t5_pend2", 0, 2'b11, OP_AND, 0, 0, 1, 0, 1);
        step("t5_rise", 0, 2'b11, OP_AND, 0, 1, 0, 1, 1);
        fall_a = 8'd0;
        step("t5_drop", 0, 2'b00, OP_AND, 0, 0, 0, 1, 1);

        // cancel via op change AND->NAND with a=11
        rise_a = 8'd4;
        step("t5_op_k0", 0, 2'b11, OP_AND, 0, 0, 1, 0, 1);
        step("t5_op_pend", 0, 2'b11, OP_AND, 0, 0, 1, 0, 1);
        step("t5_op_cancel", 0, 2'b11, OP_NAND, 0, 0, 0, 0, 2);
        step("t5_op_hold", 0, 2'b11, OP_NAND, 0, 0, 0, 0, 2);

        // revert coincident with expiry: cancelled and counted
        rise_a = 8'd3;
        step("tx_k0", 0, 2'b11, OP_AND, 0, 0, 1, 0, 2);
        step("tx_last", 0, 2'b11, OP_AND, 0, 0, 1, 0, 2);
        step("tx_revert", 0, 2'b00, OP_AND, 0, 0, 0, 0, 3);

        // maximum delay 255: 254 pending edges, z rises on the 255th
        rise_a = 8'hFF;
        for (int i = 0; i < 254; i++) step("tmax_pend", 0, 2'b11, OP_AND, 0, 0, 1, 0, 3);
        step("tmax_rise", 0, 2'b11, OP_AND, 0, 1, 0, 1, 3);
        step("tmax_hold", 0, 2'b11, OP_AND, 0, 1, 0, 0, 3);

        // ---- DUT B: INIT=1, CW=2, fall=3 ----
        step("b_rst", 1, 2'b11, OP_AND, 1, 1, 0, 0, 0);
        step("b_idle", 1, 2'b11, OP_AND, 0, 1, 0, 0, 0);
        step("b_g_k0", 1, 2'b00, OP_AND, 0, 1, 1, 0, 0);
        step("b_g_rev", 1, 2'b11, OP_AND, 0, 1, 0, 0, 1);
        step("b_p_k0", 1, 2'b00, OP_AND, 0, 1, 1, 0, 1);
        step("b_rst_pend", 1, 2'b00, OP_AND, 1, 1, 0, 0, 0);
        step("b_after_rst", 1, 2'b11, OP_AND, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step("b_sat_k0", 1, 2'b00, OP_AND, 0, 1, 1, 0, (i - 1 > 3) ? 3 : i - 1);
            step("b_sat_rev", 1, 2'b11, OP_AND, 0, 1, 0, 0, (i > 3) ? 3 : i);
        end
        step("b_final", 1, 2'b11, OP_AND, 0, 1, 0, 0, 3);

        @(posedge clk);
        #3;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
